set_bits_counter_pipe: RTL and testbench

- Pipelined, parametrised population counter for the VC-based mesh router. It counts the set bits in wide request, grant and VC-status vectors.
- Successor to the combinational set-bits counter. Adds a registered two-stage chunked adder tree with a valid strobe, a threshold flag, and a saturating running accumulator with clear.
- Used for VC-occupancy and credit statistics and for congestion thresholds at the port arbiters.

---
 rtl/set_bits_counter_pipe_if.sv | 29 ++
 rtl/set_bits_counter_pipe.sv | 146 ++++++++++++++
 tb/tb_set_bits_counter_pipe.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/set_bits_counter_pipe_if.sv
// Sample/result bundle for the pipelined set-bits counter.
// The master side presents samples and control, the slave side (the counter)
// returns the count, threshold flag and accumulator state.
interface set_bits_counter_pipe_if #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 8,
    parameter int OUT_WIDTH = $clog2(IN_WIDTH + 1)
);
    logic                 in_valid;
    logic [IN_WIDTH-1:0]  in;
    logic                 acc_en;
    logic                 acc_clr;
    logic [OUT_WIDTH-1:0] thr;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out;
    logic                 ge_thr;
    logic [ACC_WIDTH-1:0] acc;
    logic                 acc_sat;

    modport master (
        output in_valid, in, acc_en, acc_clr, thr,
        input  out_valid, out, ge_thr, acc, acc_sat
    );

    modport slave (
        input  in_valid, in, acc_en, acc_clr, thr,
        output out_valid, out, ge_thr, acc, acc_sat
    );
endinterface

// File: rtl/set_bits_counter_pipe.sv
// Pipelined population counter for request/grant/VC-status vectors.
// Stage 1 registers one partial popcount per chunk, stage 2 sums them into
// out with a one-cycle out_valid pulse, and one clock later a tagged count is
// folded into a saturating accumulator with a sticky saturation flag.

// Per-chunk popcount with a load-enabled result register.
module set_bits_counter_chunk #(
    parameter int CHUNK_WIDTH = 4,
    parameter int CNT_WIDTH   = $clog2(CHUNK_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [CHUNK_WIDTH-1:0] bits,
    output logic [CNT_WIDTH-1:0]   cnt
);
    logic [CNT_WIDTH-1:0] cnt_next;

    // Count the set bits of this chunk.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            cnt_next = cnt_next + CNT_WIDTH'(bits[i]);
        end
    end

    // Capture the partial count only for a valid sample so idle inputs are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= cnt_next;
        end
    end
endmodule

module set_bits_counter_pipe #(
    parameter int IN_WIDTH    = 16,
    parameter int CHUNK_WIDTH = 4,
    parameter int ACC_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    set_bits_counter_pipe_if.slave bus
);
    localparam int OUT_WIDTH = $clog2(IN_WIDTH + 1);
    localparam int CHUNK_NUM = (IN_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int CNT_WIDTH = $clog2(CHUNK_WIDTH + 1);
    localparam int PAD_WIDTH = CHUNK_NUM * CHUNK_WIDTH;
    // vld_pipe[0]: partial counts valid; vld_pipe[STAGES]: out valid
    localparam int STAGES    = 1;

    logic [PAD_WIDTH-1:0]                 padded;
    logic [CHUNK_NUM-1:0][CNT_WIDTH-1:0]  chunk_cnt;
    logic [STAGES:0]                      vld_pipe;
    logic [STAGES:0]                      tag_pipe;
    logic [OUT_WIDTH-1:0]                 chunk_sum;
    logic [OUT_WIDTH-1:0]                 out_q;
    logic [ACC_WIDTH-1:0]                 acc_q;
    logic                                 sat_q;
    logic                                 acc_upd;
    logic [ACC_WIDTH:0]                   acc_base;
    logic [ACC_WIDTH:0]                   out_ext;
    logic [ACC_WIDTH:0]                   acc_sum;
    logic                                 acc_hit;

    // Zero-pad the last chunk when the width is not a chunk multiple.
    always_comb begin
        padded                 = '0;
        padded[IN_WIDTH-1:0]   = bus.in;
    end

    genvar g;
    generate
        for (g = 0; g < CHUNK_NUM; g++) begin : g_chunk
            set_bits_counter_chunk #(
                .CHUNK_WIDTH (CHUNK_WIDTH),
                .CNT_WIDTH   (CNT_WIDTH)
            ) u_chunk (
                .clk  (clk),
                .reset(reset),
                .load (bus.in_valid),
                .bits (padded[g*CHUNK_WIDTH +: CHUNK_WIDTH]),
                .cnt  (chunk_cnt[g])
            );
        end
    endgenerate

    // Valid and accumulate-tag travel alongside the data; reset drops in-flight samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
            tag_pipe <= {tag_pipe[STAGES-1:0], bus.in_valid & bus.acc_en};
        end
    end

    // Adder tree over the partial counts at full result width.
    always_comb begin
        chunk_sum = '0;
        for (int i = 0; i < CHUNK_NUM; i++) begin
            chunk_sum = chunk_sum + OUT_WIDTH'(chunk_cnt[i]);
        end
    end

    // out only reloads when stage 1 holds a valid sample, otherwise it holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else if (vld_pipe[0]) begin
            out_q <= chunk_sum;
        end
    end

    // Clear-then-add: a clear in the update cycle zeroes the base, not the sum.
    always_comb begin
        acc_upd              = vld_pipe[STAGES] & tag_pipe[STAGES];
        acc_base             = bus.acc_clr ? '0 : {1'b0, acc_q};
        out_ext              = '0;
        out_ext[OUT_WIDTH-1:0] = out_q;
        acc_sum              = acc_base + out_ext;
        acc_hit              = (acc_sum >= {1'b0, {ACC_WIDTH{1'b1}}});
    end

    // Saturating accumulator with sticky saturation flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (acc_upd) begin
            acc_q <= acc_hit ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];
            sat_q <= (sat_q & ~bus.acc_clr) | acc_hit;
        end else if (bus.acc_clr) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end
    end

    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out       = out_q;
    assign bus.ge_thr    = vld_pipe[STAGES] & (out_q >= bus.thr);
    assign bus.acc       = acc_q;
    assign bus.acc_sat   = sat_q;
endmodule

// File: tb/tb_set_bits_counter_pipe.sv
// Directed bench for set_bits_counter_pipe: a cycle model derived from the
// behavioural rules is compared every cycle, plus literal expectations.
module tb_set_bits_counter_pipe;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    set_bits_counter_pipe_if #(.IN_WIDTH(16), .ACC_WIDTH(8)) bus ();
    set_bits_counter_pipe_if #(.IN_WIDTH(10), .ACC_WIDTH(8)) bus_b ();

    set_bits_counter_pipe #(.IN_WIDTH(16), .CHUNK_WIDTH(4), .ACC_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    set_bits_counter_pipe #(.IN_WIDTH(10), .CHUNK_WIDTH(4), .ACC_WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of samples; a sample shows on out one edge after capture
    // and reaches the accumulator two edges after capture.
    int h_valid [2] = '{0, 0};
    int h_cnt   [2] = '{0, 0};
    int h_tag   [2] = '{0, 0};
    int m_ov = 0, m_out = 0, m_acc = 0, m_sat = 0;
    int m_s;
    localparam int ACC_MAX = 255;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_valid = '{0, 0}; h_cnt = '{0, 0}; h_tag = '{0, 0};
            m_ov = 0; m_out = 0; m_acc = 0; m_sat = 0;
        end else begin
            if (h_valid[1] != 0 && h_tag[1] != 0) begin
                m_s   = (bus.acc_clr ? 0 : m_acc) + h_cnt[1];
                m_sat = ((bus.acc_clr ? 0 : m_sat) != 0 || m_s >= ACC_MAX) ? 1 : 0;
                m_acc = (m_s > ACC_MAX) ? ACC_MAX : m_s;
            end else if (bus.acc_clr) begin
                m_acc = 0;
                m_sat = 0;
            end
            m_ov = h_valid[0];
            if (h_valid[0] != 0) m_out = h_cnt[0];
            h_valid[1] = h_valid[0]; h_cnt[1] = h_cnt[0]; h_tag[1] = h_tag[0];
            h_valid[0] = int'(bus.in_valid);
            h_cnt[0]   = $countones(bus.in);
            h_tag[0]   = int'(bus.acc_en);
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        check("out_valid", int'(bus.out_valid), m_ov);
        check("out",       int'(bus.out),       m_out);
        check("ge_thr",    int'(bus.ge_thr),    (m_ov != 0 && m_out >= int'(bus.thr)) ? 1 : 0);
        check("acc",       int'(bus.acc),       m_acc);
        check("acc_sat",   int'(bus.acc_sat),   m_sat);
    end

    // Collect every emitted result for literal checks.
    int got[$];
    int got_ge[$];
    int got_b[$];
    always @(negedge clk) begin
        if (bus.out_valid) begin
            got.push_back(int'(bus.out));
            got_ge.push_back(int'(bus.ge_thr));
        end
        if (bus_b.out_valid) got_b.push_back(int'(bus_b.out));
    end

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic drive(input logic v, input logic [15:0] d, input logic en, input logic clr);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in       = d;
        bus.acc_en   = en;
        bus.acc_clr  = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        bus.in_valid = 0; bus.in = '0; bus.acc_en = 0; bus.acc_clr = 0; bus.thr = '0;
        bus_b.in_valid = 0; bus_b.in = '0; bus_b.acc_en = 0; bus_b.acc_clr = 0; bus_b.thr = '0;
        #2 reset = 1'b0;
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out",       int'(bus.out),       0);
        check("rst_ge_thr",    int'(bus.ge_thr),    0);
        check("rst_acc",       int'(bus.acc),       0);
        check("rst_acc_sat",   int'(bus.acc_sat),   0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // 1: single zero sample, latency of two clocks
        got.delete();
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        idle(1);
        @(negedge clk) check("t1_not_yet", int'(bus.out_valid), 0);
        @(negedge clk) check("t1_valid",   int'(bus.out_valid), 1);
        @(negedge clk) check("t1_pulse",   int'(bus.out_valid), 0);
        idle(3);
        check("t1_count", got.size(), 1);
        check("t1_out", qget(got, 0), 0);
        check("t1_acc", int'(bus.acc), 0);

        // 2: back-to-back samples
        got.delete();
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
        drive(1'b1, 16'hA5A5, 1'b0, 1'b0);
        drive(1'b1, 16'h0001, 1'b0, 1'b0);
        drive(1'b1, 16'h0003, 1'b0, 1'b0);
        drive(1'b1, 16'h0007, 1'b0, 1'b0);
        idle(4);
        check("t2_count", got.size(), 5);
        check("t2_out0", qget(got, 0), 16);
        check("t2_out1", qget(got, 1), 8);
        check("t2_out2", qget(got, 2), 1);
        check("t2_out3", qget(got, 3), 2);
        check("t2_out4", qget(got, 4), 3);
        check("t2_hold", int'(bus.out), 3);

        // 3: threshold flag
        got_ge.delete();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        bus.thr = 5'd8;
        drive(1'b1, 16'h00FF, 1'b0, 1'b0);
        idle(1);
        drive(1'b1, 16'h007F, 1'b0, 1'b0);
        idle(4);
        check("t3_count", got_ge.size(), 2);
        check("t3_ge_8", qget(got_ge, 0), 1);
        check("t3_ge_7", qget(got_ge, 1), 0);
        bus.thr = 5'd4;
        @(negedge clk) check("t3_idle_ge", int'(bus.ge_thr), 0);
        bus.thr = 5'd0;

        // 4: saturation
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        repeat (15) drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
        idle(4);
        check("t4_acc15", int'(bus.acc), 240);
        check("t4_sat15", int'(bus.acc_sat), 0);
        drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
        idle(4);
        check("t4_acc16", int'(bus.acc), 255);
        check("t4_sat16", int'(bus.acc_sat), 1);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(2);
        check("t4_clr_acc", int'(bus.acc), 0);
        check("t4_clr_sat", int'(bus.acc_sat), 0);

        // 5: clear-then-add and untagged sample
        repeat (6) drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
        drive(1'b1, 16'h000F, 1'b1, 1'b0);
        idle(4);
        check("t5_acc100", int'(bus.acc), 100);
        drive(1'b1, 16'h000F, 1'b1, 1'b0);
        idle(1);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(4);
        check("t5_clr_add", int'(bus.acc), 4);
        check("t5_clr_sat", int'(bus.acc_sat), 0);
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
        idle(4);
        check("t5_untagged", int'(bus.acc), 4);
        check("t5_out", int'(bus.out), 16);

        // 6: reset with samples in flight
        drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.in = 16'h00F0;
        #2 reset = 1'b0;
        got.delete();
        #1;
        check("t6_out",  int'(bus.out),       0);
        check("t6_acc",  int'(bus.acc),       0);
        check("t6_ov",   int'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        bus.in_valid = 0; bus.in = '0; bus.acc_en = 0;
        #1 reset = 1'b1;
        idle(5);
        check("t6_no_valid", got.size(), 0);
        check("t6_out_after", int'(bus.out), 0);
        check("t6_acc_after", int'(bus.acc), 0);

        // 6b: ten-bit configuration with a padded last chunk
        got_b.delete();
        @(posedge clk);
        #1 bus_b.in_valid = 1; bus_b.in = 10'h3FF; bus_b.acc_en = 1;
        @(posedge clk);
        #1 bus_b.in = 10'h155;
        @(posedge clk);
        #1 bus_b.in_valid = 0; bus_b.in = '0; bus_b.acc_en = 0;
        repeat (4) @(posedge clk);
        #1;
        check("t6b_count", got_b.size(), 2);
        check("t6b_out0", qget(got_b, 0), 10);
        check("t6b_out1", qget(got_b, 1), 5);
        check("t6b_acc", int'(bus_b.acc), 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
